// File: rtl/regfile_2r1w.sv
// Two-read, one-write register file with registered read ports, byte-enabled
// writes and same-cycle write-to-read bypass. DATA_W must be a multiple of 8.
module regfile_2r1w #(
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 4,
   parameter int ZERO_REG = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [ADDR_W-1:0]   read_reg_1,
   input  logic                read_en_1,
   input  logic [ADDR_W-1:0]   read_reg_2,
   input  logic                read_en_2,
   input  logic [ADDR_W-1:0]   write_reg,
   input  logic [DATA_W-1:0]   write_data,
   input  logic [DATA_W/8-1:0] write_be,
   input  logic                reg_write,
   output logic [DATA_W-1:0]   read_data_1,
   output logic                read_valid_1,
   output logic [DATA_W-1:0]   read_data_2,
   output logic                read_valid_2
);

   localparam int NUM_REGS = 2**ADDR_W;
   localparam int NB       = DATA_W/8;
   localparam bit HAS_ZERO = (ZERO_REG != 0);

   logic [DATA_W-1:0] regs_q [NUM_REGS];
   logic [DATA_W-1:0] wr_word_d;
   logic              wr_en;
   logic [DATA_W-1:0] rd_data_1_d, rd_data_1_q;
   logic [DATA_W-1:0] rd_data_2_d, rd_data_2_q;
   logic              rd_valid_1_q, rd_valid_2_q;

   // Post-write image of the target register; feeds both the array and the bypass.
   always_comb begin
      wr_word_d = regs_q[write_reg];
      for (int b = 0; b < NB; b++)
         if (write_be[b]) wr_word_d[8*b +: 8] = write_data[8*b +: 8];
   end

   assign wr_en = reg_write && !(HAS_ZERO && (write_reg == '0));

   always_comb begin
      rd_data_1_d = regs_q[read_reg_1];
      if (wr_en && (read_reg_1 == write_reg)) rd_data_1_d = wr_word_d;
      if (HAS_ZERO && (read_reg_1 == '0))     rd_data_1_d = '0;
   end

   always_comb begin
      rd_data_2_d = regs_q[read_reg_2];
      if (wr_en && (read_reg_2 == write_reg)) rd_data_2_d = wr_word_d;
      if (HAS_ZERO && (read_reg_2 == '0))     rd_data_2_d = '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      end else if (wr_en) begin
         regs_q[write_reg] <= wr_word_d;
      end
   end

   // Read data holds when the port is idle; valid is a one-cycle pulse per read.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data_1_q  <= '0;
         rd_data_2_q  <= '0;
         rd_valid_1_q <= 1'b0;
         rd_valid_2_q <= 1'b0;
      end else begin
         if (read_en_1) rd_data_1_q <= rd_data_1_d;
         if (read_en_2) rd_data_2_q <= rd_data_2_d;
         rd_valid_1_q <= read_en_1;
         rd_valid_2_q <= read_en_2;
      end
   end

   assign read_data_1  = rd_data_1_q;
   assign read_data_2  = rd_data_2_q;
   assign read_valid_1 = rd_valid_1_q;
   assign read_valid_2 = rd_valid_2_q;

endmodule

// File: doc/regfile_2r1w.md
# regfile_2r1w

Parametrised two-read, one-write register file for the 16-bit MIPS-style datapath. It replaces the single-size register array with configurable data width and register count, registered read ports with per-port enables and valid flags, byte-enabled writes, and same-cycle write-to-read bypass. Reads are no longer suppressed during writes. It sits between decode (read addresses) and writeback (write port).

## Interface
- DATA_W, 16: data width in bits; must be a multiple of 8.
- ADDR_W, 4: register address width; register count NUM_REGS = 2**ADDR_W.
- ZERO_REG, 1: 1 = register 0 is hardwired to zero; 0 = register 0 is a normal register.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- read_reg_1  in  ADDR_W  port-1 read address.
- read_en_1  in  1  port-1 read request.
- read_reg_2  in  ADDR_W  port-2 read address.
- read_en_2  in  1  port-2 read request.
- write_reg  in  ADDR_W  write address.
- write_data  in  DATA_W  write data.
- write_be  in  DATA_W/8  byte enables; bit i covers write_data[8i+7:8i].
- reg_write  in  1  write strobe.
- read_data_1  out  DATA_W  port-1 registered read data.
- read_valid_1  out  1  read_data_1 holds the result of a read issued the previous cycle.
- read_data_2  out  DATA_W  port-2 registered read data.
- read_valid_2  out  1  same, for port 2.

## Operation
- Storage: NUM_REGS x DATA_W array.
- Reset (rst=1 at an edge): every register cleared to 0; read_data_1/2 = 0; read_valid_1/2 = 0. Reset takes priority over any write or read in the same cycle. Neither the write nor the reads are performed.
- Write: when reg_write=1 at an edge, update each byte of registers[write_reg] whose write_be bit is 1. Bytes with write_be=0 keep their value. reg_write=1 with write_be all zero is a no-op.
- ZERO_REG=1: writes to address 0 are discarded, and reads of address 0 always return 0, including through the bypass.
- Read, per port independently: when read_en_n=1 at an edge, read_data_n is loaded with the selected value and read_valid_n is set to 1 for the next cycle.
  - When read_en_n=0, read_data_n holds its last value and read_valid_n = 0.
- Bypass: when a read and a write target the same address in the same cycle, the returned value is the post-write value. Each byte comes from write_data if its write_be bit is 1, otherwise from the stored value. This also applies when both ports read the written address.
- A write never blocks or zeroes a read. Reads and writes proceed every cycle.
- Out-of-range addresses do not occur: the array is a full power of two.

## Timing
- Read latency: 1 cycle. Address and enable are sampled at edge N; data and valid are visible after edge N until edge N+1.
- Write latency: data sampled at edge N. It is visible to a read issued at edge N through the bypass, and from the array thereafter.
- Throughput: one write plus two reads per cycle, sustained, with no stalls.
- Reset mid-operation: a read issued in the cycle rst is asserted produces read_valid=0 and data 0. The first valid read is one issued at the edge after rst deasserts.
- There is no combinational path from any input to any output.

## Test plan
- Reset: drive arbitrary traffic, then assert rst for 1 cycle -> read_valid_1/2=0 and read_data_1/2=0x0000. Subsequent reads of r1..r15 return 0x0000.
- Basic write/read: write r5=0xBEEF with be=2'b11. Next cycle read_reg_1=5, read_en_1=1 -> the following cycle read_data_1=0xBEEF and read_valid_1=1.
- Byte enable: r3=0x1234, then write 0xABCD with be=2'b01 -> read r3 returns 0x12CD. Write be=2'b00 -> r3 is unchanged.
- Bypass: r7=0x1111, then in the same cycle write r7=0x2222 with be=2'b10 and read r7 on both ports -> both ports return 0x2211.
- Zero register (ZERO_REG=1): write r0=0xFFFF, then read r0 -> 0x0000, including the same-cycle bypass case. Re-run with ZERO_REG=0 -> read returns 0xFFFF.
- Enable/hold and parameters: read r2 (0x00A5), then drop read_en_1 -> read_valid_1=0 and read_data_1 holds 0x00A5. Repeat the write/read and bypass checks with DATA_W=32, ADDR_W=5, using r31 and be=4'b0101.
